// File: rtl/lsu_bus_master.sv
// Load/store unit bus master: turns one pipeline load/store request at a
// time into 64-bit data-memory reads and writes. Sub-word stores use
// read-modify-write. Misaligned accesses return an error response
// without touching the bus.
module lsu_bus_master #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_unsigned_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              resp_valid_o,
  output logic [DATA_W-1:0] resp_rdata_o,
  output logic              resp_err_o,
  output logic              mem_rd_en_o,
  output logic              mem_wr_en_o,
  output logic [63:0]       addr_mem_rd_o,
  output logic [63:0]       addr_mem_wr_o,
  output logic [DATA_W-1:0] data_mem_wr_o,
  input  logic [DATA_W-1:0] data_mem_rd_i
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD      = 3'd1;
  localparam logic [2:0] S_RD_DATA = 3'd2;
  localparam logic [2:0] S_WR      = 3'd3;
  localparam logic [2:0] S_RESP    = 3'd4;

  logic [2:0]  state_reg, state_next;
  logic [63:0] bus_addr_reg;
  logic [2:0]  lane_reg;
  logic [1:0]  size_reg;
  logic        we_reg;
  logic        unsigned_reg;
  logic [63:0] wdata_reg;
  logic [63:0] word_reg;   // load result, merged RMW word, or double store data
  logic        err_reg;

  logic [63:0] addr_ext;
  logic        misaligned;
  logic [5:0]  shamt;
  logic [63:0] size_mask;
  logic [63:0] rd_shifted;
  logic [63:0] load_ext;
  logic        load_sign;
  logic [63:0] lane_mask;
  logic [63:0] rmw_merged;

  // Bring the request address to a 64-bit bus address regardless of ADDR_W.
  generate
    if (ADDR_W >= 64) begin : g_addr_wide
      assign addr_ext = req_addr_i[63:0];
    end else begin : g_addr_narrow
      assign addr_ext = {{(64-ADDR_W){1'b0}}, req_addr_i};
    end
  endgenerate

  // Alignment check on the incoming request.
  always_comb begin
    misaligned = 1'b0;
    case (req_size_i)
      2'd1:    misaligned = req_addr_i[0];
      2'd2:    misaligned = |req_addr_i[1:0];
      2'd3:    misaligned = |req_addr_i[2:0];
      default: misaligned = 1'b0;
    endcase
  end

  // Load extraction/extension and RMW merge, both from the captured read word.
  always_comb begin
    shamt      = {lane_reg, 3'b000};
    size_mask  = 64'hFFFF_FFFF_FFFF_FFFF;
    load_sign  = 1'b0;
    rd_shifted = data_mem_rd_i >> shamt;
    case (size_reg)
      2'd0: begin size_mask = 64'h0000_0000_0000_00FF; load_sign = rd_shifted[7];  end
      2'd1: begin size_mask = 64'h0000_0000_0000_FFFF; load_sign = rd_shifted[15]; end
      2'd2: begin size_mask = 64'h0000_0000_FFFF_FFFF; load_sign = rd_shifted[31]; end
      default: begin size_mask = 64'hFFFF_FFFF_FFFF_FFFF; load_sign = rd_shifted[63]; end
    endcase
    load_ext   = (rd_shifted & size_mask) |
                 ((load_sign && !unsigned_reg) ? ~size_mask : 64'd0);
    lane_mask  = size_mask << shamt;
    rmw_merged = (data_mem_rd_i & ~lane_mask) | ((wdata_reg & size_mask) << shamt);
  end

  // Next-state selection for the request sequencer.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (req_valid_i) begin
          if (misaligned)                           state_next = S_RESP;
          else if (req_we_i && req_size_i == 2'd3)  state_next = S_WR;
          else                                      state_next = S_RD;
        end
      end
      S_RD:      state_next = S_RD_DATA;
      S_RD_DATA: state_next = we_reg ? S_WR : S_RESP;
      S_WR:      state_next = S_RESP;
      S_RESP:    state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  // State and request registers; capture on acceptance and in RD_DATA.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      bus_addr_reg <= 64'd0;
      lane_reg     <= 3'd0;
      size_reg     <= 2'd0;
      we_reg       <= 1'b0;
      unsigned_reg <= 1'b0;
      wdata_reg    <= 64'd0;
      word_reg     <= 64'd0;
      err_reg      <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == S_IDLE && req_valid_i) begin
        bus_addr_reg <= addr_ext & ~64'h7;
        lane_reg     <= req_addr_i[2:0];
        size_reg     <= req_size_i;
        we_reg       <= req_we_i;
        unsigned_reg <= req_unsigned_i;
        wdata_reg    <= req_wdata_i;
        word_reg     <= req_wdata_i;   // used directly by double stores
        err_reg      <= misaligned;
      end
      if (state_reg == S_RD_DATA) begin
        word_reg <= we_reg ? rmw_merged : load_ext;
      end
    end
  end

  // Outputs decoded from the state; response fields read 0 outside RESP.
  assign req_ready_o   = (state_reg == S_IDLE);
  assign mem_rd_en_o   = (state_reg == S_RD);
  assign mem_wr_en_o   = (state_reg == S_WR);
  assign addr_mem_rd_o = bus_addr_reg;
  assign addr_mem_wr_o = bus_addr_reg;
  assign data_mem_wr_o = (state_reg == S_WR) ? word_reg : 64'd0;
  assign resp_valid_o  = (state_reg == S_RESP);
  assign resp_err_o    = (state_reg == S_RESP) && err_reg;
  assign resp_rdata_o  = (state_reg == S_RESP && !we_reg && !err_reg) ? word_reg : 64'd0;

endmodule

// File: tb/tb_lsu_bus_master.sv
// Randomized scoreboard bench for lsu_bus_master with a byte-level
// reference model and a 256-byte memory slave.
module tb_lsu_bus_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_we_i = 1'b0;
  logic [1:0]  req_size_i = 2'd0;
  logic        req_unsigned_i = 1'b0;
  logic [63:0] req_addr_i = 64'd0;
  logic [63:0] req_wdata_i = 64'd0;
  logic        resp_valid_o;
  logic [63:0] resp_rdata_o;
  logic        resp_err_o;
  logic        mem_rd_en_o;
  logic        mem_wr_en_o;
  logic [63:0] addr_mem_rd_o;
  logic [63:0] addr_mem_wr_o;
  logic [63:0] data_mem_wr_o;
  logic [63:0] data_mem_rd_i = 64'd0;

  lsu_bus_master #(.ADDR_W(64), .DATA_W(64)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_we_i(req_we_i), .req_size_i(req_size_i),
    .req_unsigned_i(req_unsigned_i), .req_addr_i(req_addr_i),
    .req_wdata_i(req_wdata_i),
    .resp_valid_o(resp_valid_o), .resp_rdata_o(resp_rdata_o),
    .resp_err_o(resp_err_o),
    .mem_rd_en_o(mem_rd_en_o), .mem_wr_en_o(mem_wr_en_o),
    .addr_mem_rd_o(addr_mem_rd_o), .addr_mem_wr_o(addr_mem_wr_o),
    .data_mem_wr_o(data_mem_wr_o), .data_mem_rd_i(data_mem_rd_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
    int          lat;
    int          rd;
    int          wr;
    logic [63:0] baddr;
    int          acc;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] ref_mem[32];
  logic [63:0] bus_mem[32];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  bit          started = 1'b0;
  bit          in_rst_test = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory slave: registered read data, write on enable.
  always @(posedge clk) begin
    if (mem_rd_en_o) data_mem_rd_i <= bus_mem[addr_mem_rd_o[7:3]];
    if (mem_wr_en_o) bus_mem[addr_mem_wr_o[7:3]] = data_mem_wr_o;
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: byte-wise gather/scatter on the reference memory image.
  task automatic model(input bit we, input logic [1:0] size, input bit uns,
                       input logic [63:0] addr, input logic [63:0] wdata,
                       output logic [63:0] rdata, output bit err);
    int n;
    int lane;
    int idx;
    logic [63:0] w;
    logic [63:0] v;
    n     = 1 << size;
    lane  = int'(addr % 8);
    idx   = int'((addr % 256) / 8);
    err   = (addr % n) != 0;
    rdata = 64'd0;
    if (err) return;
    w = ref_mem[idx];
    if (!we) begin
      v = 64'd0;
      for (int i = 0; i < n; i++) v[8*i +: 8] = w[8*(lane+i) +: 8];
      if (!uns && v[8*n-1])
        for (int i = n; i < 8; i++) v[8*i +: 8] = 8'hFF;
      rdata = v;
    end else begin
      for (int i = 0; i < n; i++) w[8*(lane+i) +: 8] = wdata[8*i +: 8];
      ref_mem[idx] = w;
    end
  endtask

  // Drive one request at a negedge, wait for acceptance, push expectation.
  task automatic issue(input bit we, input logic [1:0] size, input bit uns,
                       input logic [63:0] addr, input logic [63:0] wdata,
                       input bit use_exp, input logic [63:0] exp_val);
    exp_t e;
    logic [63:0] rd;
    bit err;
    int n;
    model(we, size, uns, addr, wdata, rd, err);
    req_valid_i    = 1'b1;
    req_we_i       = we;
    req_size_i     = size;
    req_unsigned_i = uns;
    req_addr_i     = addr;
    req_wdata_i    = wdata;
    n = 0;
    while (!req_ready_o) begin
      @(negedge clk);
      n++;
      if (n > 20) begin
        n_checks++;
        n_fail++;
        $display("FAIL accept_timeout: ready stayed 0 for addr %h", addr);
        req_valid_i = 1'b0;
        return;
      end
    end
    e.rdata = use_exp ? exp_val : rd;
    e.err   = err;
    e.lat   = err ? 1 : (we ? ((size == 2'd3) ? 2 : 4) : 3);
    e.rd    = (err || (we && size == 2'd3)) ? 0 : 1;
    e.wr    = (we && !err) ? 1 : 0;
    e.baddr = addr & ~64'h7;
    e.acc   = cyc;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    req_valid_i = 1'b0;
  endtask

  // Monitor: bus sanity per cycle, response compare against scoreboard head.
  always @(negedge clk) begin
    if (!rst && started) begin
      if (mem_rd_en_o && mem_wr_en_o) check("rd_wr_exclusive", 64'd1, 64'd0);
      if (mem_rd_en_o || mem_wr_en_o) begin
        if (sb.size() == 0) begin
          if (!in_rst_test) check("enable_without_txn", 64'd1, 64'd0);
        end else begin
          if (mem_rd_en_o) begin
            check("rd_addr", addr_mem_rd_o, sb[0].baddr);
            rd_cnt++;
          end
          if (mem_wr_en_o) begin
            check("wr_addr", addr_mem_wr_o, sb[0].baddr);
            wr_cnt++;
          end
        end
      end
      if (resp_valid_o) begin
        if (sb.size() == 0) begin
          check("unexpected_resp", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("resp_rdata", resp_rdata_o, e.rdata);
          check("resp_err", {63'd0, resp_err_o}, {63'd0, e.err});
          check("latency", 64'(cyc - e.acc), 64'(e.lat));
          check("rd_enable_count", 64'(rd_cnt), 64'(e.rd));
          check("wr_enable_count", 64'(wr_cnt), 64'(e.wr));
          $display("txn addr=%h err=%0b rdata=%h lat=%0d", e.baddr, resp_err_o, resp_rdata_o, cyc - e.acc);
        end
        rd_cnt = 0;
        wr_cnt = 0;
      end else begin
        check("idle_resp_zero", {resp_rdata_o[62:0], resp_err_o}, 64'd0);
      end
    end
  end

  initial begin
    logic [63:0] a;
    logic [1:0]  sz;
    int          n;
    for (int i = 0; i < 32; i++) begin
      a = {$urandom, $urandom};
      ref_mem[i] = a;
      bus_mem[i] = a;
    end
    ref_mem[2] = 64'h8877665544332211;
    bus_mem[2] = 64'h8877665544332211;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {63'd0, req_ready_o}, 64'd1);
    check("rst_enables", {62'd0, mem_rd_en_o, mem_wr_en_o}, 64'd0);
    check("rst_resp_valid", {63'd0, resp_valid_o}, 64'd0);
    check("rst_addr_rd", addr_mem_rd_o, 64'd0);
    check("rst_data_wr", data_mem_wr_o, 64'd0);
    rst = 1'b0;
    started = 1'b1;

    // Directed cases on word 0x10
    issue(1'b0, 2'd0, 1'b0, 64'h17, 64'd0, 1'b1, 64'hFFFFFFFFFFFFFF88);
    issue(1'b0, 2'd1, 1'b1, 64'h12, 64'd0, 1'b1, 64'h0000000000004433);
    issue(1'b0, 2'd2, 1'b0, 64'h14, 64'd0, 1'b1, 64'hFFFFFFFF88776655);
    issue(1'b1, 2'd1, 1'b0, 64'h16, 64'hBEEF, 1'b1, 64'd0);
    issue(1'b0, 2'd3, 1'b0, 64'h10, 64'd0, 1'b1, 64'hBEEF665544332211);
    issue(1'b1, 2'd3, 1'b0, 64'h08, 64'h0123456789ABCDEF, 1'b1, 64'd0);
    issue(1'b0, 2'd2, 1'b0, 64'h06, 64'd0, 1'b1, 64'd0);
    issue(1'b0, 2'd3, 1'b0, 64'h08, 64'd0, 1'b1, 64'h0123456789ABCDEF);

    // Randomized traffic, mostly aligned, sometimes back-to-back
    for (int t = 0; t < 250; t++) begin
      sz = 2'($urandom_range(0, 3));
      a  = 64'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) a = a & ~(64'((1 << sz) - 1));
      issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a,
            {$urandom, $urandom}, 1'b0, 64'd0);
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
    end

    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) check("drain_timeout", 64'(sb.size()), 64'd0);
    repeat (2) @(negedge clk);

    // Reset during RD_DATA of a sub-word store
    in_rst_test    = 1'b1;
    req_valid_i    = 1'b1;
    req_we_i       = 1'b1;
    req_size_i     = 2'd0;
    req_unsigned_i = 1'b0;
    req_addr_i     = 64'h23;
    req_wdata_i    = 64'h5A;
    check("rt_ready_before", {63'd0, req_ready_o}, 64'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid_i = 1'b0;
    check("rt_rd_phase", {63'd0, mem_rd_en_o}, 64'd1);
    @(posedge clk);
    @(negedge clk);
    check("rt_rd_data_no_en", {62'd0, mem_rd_en_o, mem_wr_en_o}, 64'd0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rt_ready_after", {63'd0, req_ready_o}, 64'd1);
    for (int k = 0; k < 5; k++) begin
      check("rt_no_wr", {63'd0, mem_wr_en_o}, 64'd0);
      check("rt_no_resp", {63'd0, resp_valid_o}, 64'd0);
      @(negedge clk);
    end
    in_rst_test = 1'b0;

    // Final memory image
    for (int i = 0; i < 32; i++) check("mem_image", bus_mem[i], ref_mem[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_bus_master.md
LSU_BUS_MASTER -- requirements
Module: lsu_bus_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 64, byte-address width.
REQ-002 SHALL have parameter DATA_W, default 64, data-memory word width (fixed at 64; other values unsupported).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port req_valid_i  input  1  pipeline load/store request valid.
REQ-006 SHALL have port req_ready_o  output  1  request accepted when req_valid_i && req_ready_o.
REQ-007 SHALL have port req_we_i  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_size_i  input  2  access size: 0 = byte, 1 = half, 2 = word, 3 = double.
REQ-009 SHALL have port req_unsigned_i  input  1  load zero-extends when 1, sign-extends when 0.
REQ-010 SHALL have port req_addr_i  input  ADDR_W  byte address.
REQ-011 SHALL have port req_wdata_i  input  64  store data, LSB-aligned.
REQ-012 SHALL have port resp_valid_o  output  1  one-cycle completion pulse.
REQ-013 SHALL have port resp_rdata_o  output  64  extended load result; 0 for stores.
REQ-014 SHALL have port resp_err_o  output  1  misaligned access; valid with resp_valid_o.
REQ-015 SHALL have port mem_rd_en_o  output  1  data-memory read enable, active-high.
REQ-016 SHALL have port mem_wr_en_o  output  1  data-memory write enable, active-high.
REQ-017 SHALL have port addr_mem_rd_o  output  64  read address.
REQ-018 SHALL have port addr_mem_wr_o  output  64  write address.
REQ-019 SHALL have port data_mem_wr_o  output  64  write data.
REQ-020 SHALL have port data_mem_rd_i  input  64  read data, registered by memory, valid the cycle after mem_rd_en_o.

Function
REQ-021 SHALL implement states IDLE, RD, RD_DATA, WR, RESP; req_ready_o = 1 only in IDLE.
REQ-022 SHALL, on acceptance, register addr, size, we, unsigned, wdata; bus address = {addr[63:3],3'b000}; byte lane = addr[2:0], little-endian.
REQ-023 SHALL detect misalignment (half: addr[0]!=0; word: addr[1:0]!=0; double: addr[2:0]!=0), go IDLE->RESP with resp_err_o=1, resp_rdata_o=0, and drive no enable.
REQ-024 SHALL route aligned loads IDLE->RD->RD_DATA->RESP->IDLE.
REQ-025 SHALL route double stores IDLE->WR->RESP->IDLE.
REQ-026 SHALL route byte/half/word stores IDLE->RD->RD_DATA->WR->RESP->IDLE (read-modify-write).
REQ-027 SHALL assert mem_rd_en_o=1 only in RD and mem_wr_en_o=1 only in WR, never both in the same cycle.
REQ-028 SHALL, in RD_DATA, capture data_mem_rd_i; loads shift right by lane*8, mask to size, and sign- or zero-extend into the result register; RMW merges the size-masked wdata into the selected lanes, leaving other bytes unchanged.
REQ-029 SHALL drive data_mem_wr_o in WR with the merged word (RMW) or the registered wdata (double).
REQ-030 SHALL hold addr_mem_rd_o and addr_mem_wr_o at the registered bus address throughout an operation; they hold their last value otherwise.
REQ-031 SHALL assert resp_valid_o for exactly one cycle (RESP) with no backpressure; resp_rdata_o and resp_err_o stay valid only that cycle and read 0 otherwise.
REQ-032 SHALL have latency from acceptance edge to resp_valid_o of: load 3 cycles, double store 2, sub-word store 4, misaligned 1.
REQ-033 SHALL ignore req_valid_i outside IDLE; a request held valid through RESP is accepted in the following IDLE cycle.

Reset
REQ-034 SHALL, when rst=1 at an edge, enter IDLE and clear all outputs to 0 except req_ready_o, which SHALL be 1 in the next cycle.
REQ-035 SHALL, on reset mid-operation, abandon the operation, issue no further enables, and produce no response; a write already performed in WR is not undone.

Verification
REQ-036 SHALL pass: mem[0x10]=0x8877665544332211, load byte addr 0x17 signed -> resp_rdata_o=0xFFFFFFFFFFFFFF88, 3 cycles after acceptance.
REQ-037 SHALL pass: same word, load half addr 0x12 unsigned -> 0x0000000000004433; load word addr 0x14 signed -> 0xFFFFFFFF88776655.
REQ-038 SHALL pass: store half 0xBEEF to addr 0x16 -> single RD then single WR, data_mem_wr_o=0xBEEF665544332211, resp 4 cycles after acceptance.
REQ-039 SHALL pass: store double 0x0123456789ABCDEF to addr 0x08 -> mem_rd_en_o never asserted, one WR cycle, resp after 2 cycles.
REQ-040 SHALL pass: load word addr 0x06 -> resp_err_o=1 with resp_valid_o 1 cycle after acceptance, no enables asserted.
REQ-041 SHALL pass: rst asserted during RD_DATA of a sub-word store -> mem_wr_en_o stays 0, no resp_valid_o, req_ready_o=1 the cycle after reset.
